idiom_detect_seq: RTL

// - Parametrised successor of the core controller's hard-wired divide-loop detector.
// - Keeps a sliding history of fetched instruction pairs.
// - Compares the window against NUM_IDIOMS run-time programmable value/mask patterns.
// - On a hit, captures two operands and issues a req/ack handshake to an accelerator.
// - Sits beside ctrl, between fetch/decode and the accelerator cluster.

---
 rtl/idiom_detect_seq_pkg.sv | 17 +
 rtl/idiom_detect_seq_match_slot.sv | 23 ++
 rtl/idiom_detect_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/idiom_detect_seq_pkg.sv
// Shared types and constants for the instruction-idiom detector.
package idiom_detect_seq_pkg;

    typedef enum logic [1:0] {
        IDM_IDLE,
        IDM_REQ,
        IDM_COOL
    } t_idm_state;

    localparam int IDM_DROP_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [IDM_DROP_W-1:0] sat_inc(input logic [IDM_DROP_W-1:0] v);
        return (&v) ? v : v + IDM_DROP_W'(1);
    endfunction

endpackage

// File: rtl/idiom_detect_seq_match_slot.sv
// One pattern slot: masked compare of every window word, gated by that word's valid bit.
module idiom_match_slot #(
    parameter int WIDTH = 16,
    parameter int WIN   = 24
) (
    input  logic                       en_i,
    input  logic [WIN-1:0][WIDTH-1:0]  win_i,
    input  logic [WIN-1:0]             vld_i,
    input  logic [WIN-1:0][WIDTH-1:0]  val_i,
    input  logic [WIN-1:0][WIDTH-1:0]  mask_i,
    output logic                       hit_o
);

    logic [WIN-1:0] word_ok;

    // A fully masked word still demands a valid entry behind it.
    for (genvar k = 0; k < WIN; k++) begin : g_word
        assign word_ok[k] = vld_i[k] && (((win_i[k] ^ val_i[k]) & mask_i[k]) == '0);
    end

    assign hit_o = en_i & (&word_ok);

endmodule

// File: rtl/idiom_detect_seq.sv
// Sliding fetch-history idiom detector that hands captured operands to an accelerator.
module idiom_detect_seq
    import idiom_detect_seq_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int DEPTH      = 12,
    parameter  int NUM_IDIOMS = 4,
    parameter  int COOLDOWN   = 4,
    localparam int WIN        = 2 * DEPTH,
    localparam int IDX_W      = $clog2(WIN),
    localparam int ID_W       = (NUM_IDIOMS > 1) ? $clog2(NUM_IDIOMS) : 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        shift_en_i,
    input  logic [1:0][WIDTH-1:0]                       inst_pair_i,
    input  logic                                        flush_i,
    input  logic [NUM_IDIOMS-1:0]                       idiom_en_i,
    input  logic [NUM_IDIOMS-1:0][WIN-1:0][WIDTH-1:0]   pat_val_i,
    input  logic [NUM_IDIOMS-1:0][WIN-1:0][WIDTH-1:0]   pat_mask_i,
    input  logic [NUM_IDIOMS-1:0][IDX_W-1:0]            op_idx_a_i,
    input  logic [NUM_IDIOMS-1:0][IDX_W-1:0]            op_idx_b_i,
    output logic                                        acc_req_o,
    output logic [ID_W-1:0]                             acc_id_o,
    output logic [WIDTH-1:0]                            acc_op_a_o,
    output logic [WIDTH-1:0]                            acc_op_b_o,
    input  logic                                        acc_ack_i,
    output logic                                        busy_o,
    output logic [IDM_DROP_W-1:0]                       drop_cnt_o
);

    localparam int CNT_W = 4;

    logic [WIN-1:0][WIDTH-1:0] win_q, win_d;
    logic [WIN-1:0]            vld_q, vld_d;
    t_idm_state                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [WIDTH-1:0]          opa_q, opa_d, opb_q, opb_d;
    logic [IDM_DROP_W-1:0]     drop_q, drop_d;

    logic [NUM_IDIOMS-1:0]     hit;
    logic                      any_hit;
    logic [ID_W-1:0]           win_id;
    logic [IDX_W-1:0]          idx_a, idx_b;
    logic [WIDTH-1:0]          op_a, op_b;

    // W[0] is the newest word; a flush wins over a same-cycle shift.
    always_comb begin
        win_d = win_q;
        vld_d = vld_q;
        if (flush_i) begin
            vld_d = '0;
        end else if (shift_en_i) begin
            win_d = {win_q[WIN-3:0], inst_pair_i[0], inst_pair_i[1]};
            vld_d = {vld_q[WIN-3:0], 2'b11};
        end
    end

    for (genvar i = 0; i < NUM_IDIOMS; i++) begin : g_slot
        idiom_match_slot #(.WIDTH(WIDTH), .WIN(WIN)) u_slot (
            .en_i   (idiom_en_i[i]),
            .win_i  (win_q),
            .vld_i  (vld_q),
            .val_i  (pat_val_i[i]),
            .mask_i (pat_mask_i[i]),
            .hit_o  (hit[i])
        );
    end

    always_comb begin
        win_id  = '0;
        any_hit = |hit;
        for (int i = NUM_IDIOMS - 1; i >= 0; i--) begin
            if (hit[i]) win_id = ID_W'(i);
        end
    end

    // Out-of-range operand indices are a configuration error and yield a clean zero.
    always_comb begin
        idx_a = op_idx_a_i[win_id];
        idx_b = op_idx_b_i[win_id];
        op_a  = (32'(idx_a) < WIN) ? win_q[idx_a] : '0;
        op_b  = (32'(idx_b) < WIN) ? win_q[idx_b] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q   <= '0;
            vld_q   <= '0;
            state_q <= IDM_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            drop_q  <= '0;
        end else begin
            win_q   <= win_d;
            vld_q   <= vld_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDM_IDLE: begin
                if (any_hit) begin
                    state_d = IDM_REQ;
                    id_d    = win_id;
                    opa_d   = op_a;
                    opb_d   = op_b;
                end
            end
            IDM_REQ: begin
                if (flush_i) begin
                    state_d = IDM_IDLE;
                end else if (acc_ack_i) begin
                    state_d = IDM_COOL;
                    cnt_d   = CNT_W'(COOLDOWN - 1);
                end
            end
            IDM_COOL: begin
                if (flush_i || cnt_q == '0) state_d = IDM_IDLE;
                else                        cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDM_IDLE;
        endcase
        // One drop per fresh window that hits while the accelerator path is occupied.
        if (state_q != IDM_IDLE && any_hit && shift_en_i) drop_d = sat_inc(drop_q);
    end

    always_comb begin
        acc_req_o  = (state_q == IDM_REQ);
        busy_o     = (state_q != IDM_IDLE);
        acc_id_o   = id_q;
        acc_op_a_o = opa_q;
        acc_op_b_o = opb_q;
        drop_cnt_o = drop_q;
    end

endmodule
